// File: rtl/alu_pkg.sv
// Shared types for the ALU execute stage: operation codes, FSM states and
// width defaults.
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 5;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_XOR  = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SRA  = 4'b0111,
    OP_EQ   = 4'b1000,
    OP_NE   = 4'b1001,
    OP_LT   = 4'b1011,
    OP_OR   = 4'b1101,
    OP_LINK = 4'b1110,
    OP_GE   = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational datapath for every non-shift operation code.
// Shift codes fall through to zero here; the iterative shifter owns them.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              cmp
);

  localparam logic [DATA_W-1:0] LINK_INC = DATA_W'(4);

  logic lt;
  assign lt = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    cmp    = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_LINK: result = a + LINK_INC;
      // Compare codes mirror the flag into bit 0 of the result.
      OP_EQ: begin cmp = (a == b); result = DATA_W'(cmp); end
      OP_NE: begin cmp = (a != b); result = DATA_W'(cmp); end
      OP_LT: begin cmp = lt;       result = DATA_W'(cmp); end
      OP_GE: begin cmp = !lt;      result = DATA_W'(cmp); end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: valid/ready handshake around a single-cycle core plus a
// one-bit-per-cycle shifter. Results sit in DONE until downstream takes them.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        Operation,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_cmp,
  output logic [TAG_W-1:0]  out_tag
);

  state_e            state;
  logic [4:0]        sh_cnt;
  logic [DATA_W-1:0] sh_val;
  logic [DATA_W-1:0] sh_next;
  logic [3:0]        sh_op;
  logic [DATA_W-1:0] core_result;
  logic              core_cmp;
  logic [4:0]        shamt;
  logic              accept;
  logic              start_shift;

  alu_core #(.DATA_W(DATA_W)) u_core (
    .op     (Operation),
    .a      (SrcA),
    .b      (SrcB),
    .result (core_result),
    .cmp    (core_cmp)
  );

  assign shamt       = SrcB[4:0];
  assign in_ready    = !reset && !flush &&
                       (state == S_IDLE || (state == S_DONE && out_ready));
  assign accept      = in_valid && in_ready;
  assign start_shift = is_shift(Operation) && (shamt != 5'd0);

  always_comb begin
    sh_next = sh_val >> 1;
    if (sh_op == OP_SLL)      sh_next = sh_val << 1;
    else if (sh_op == OP_SRA) sh_next = {sh_val[DATA_W-1], sh_val[DATA_W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_cmp    <= 1'b0;
      out_tag    <= '0;
      sh_cnt     <= '0;
      sh_val     <= '0;
      sh_op      <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_SHIFT: begin
          sh_val <= sh_next;
          sh_cnt <= sh_cnt - 5'd1;
          // Last step lands straight in the output register.
          if (sh_cnt == 5'd1) begin
            state      <= S_DONE;
            out_valid  <= 1'b1;
            out_result <= sh_next;
            out_cmp    <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            out_tag <= in_tag;
            if (start_shift) begin
              state     <= S_SHIFT;
              out_valid <= 1'b0;
              sh_val    <= SrcA;
              sh_cnt    <= shamt;
              sh_op     <= Operation;
            end else begin
              state      <= S_DONE;
              out_valid  <= 1'b1;
              out_result <= is_shift(Operation) ? SrcA : core_result;
              out_cmp    <= core_cmp;
            end
          end else if (state == S_DONE && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a transaction-level reference model
// checked on every cycle, plus literal expectations for key corner cases.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_cmp;
  logic [4:0]  out_tag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_consumed = 0;

  // Reference model state: at most one operation in flight.
  bit          have_op = 1'b0;
  int          avail = 0;
  logic [31:0] e_res;
  logic        e_cmp;
  logic [4:0]  e_tag;

  alu_exec_stage #(.DATA_W(32), .TAG_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Operation  (Operation),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cmp    (out_cmp),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Returns {cmp, result} straight from the operation table.
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic c;
    sa = a;
    c  = 1'b0;
    case (op)
      4'b0000: return {1'b0, a & b};
      4'b0001: return {1'b0, a ^ b};
      4'b0010: return {1'b0, a + b};
      4'b0100: return {1'b0, a << b[4:0]};
      4'b0101: return {1'b0, a >> b[4:0]};
      4'b0111: return {1'b0, 32'(sa >>> b[4:0])};
      4'b1000: c = (a == b);
      4'b1001: c = (a != b);
      4'b1011: c = ($signed(a) < $signed(b));
      4'b1101: return {1'b0, a | b};
      4'b1110: return {1'b0, a + 32'd4};
      4'b1111: c = ($signed(a) >= $signed(b));
      default: return 33'd0;
    endcase
    return {c, 31'd0, c};
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'b0100 || op == 4'b0101 || op == 4'b0111) return 1 + int'(b[4:0]);
    return 1;
  endfunction

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin : monitor
    logic exp_valid;
    logic exp_ready;
    logic [32:0] r;
    if (reset) begin
      chk("rst_in_ready", in_ready, 1'b0);
      have_op = 1'b0;
    end else begin
      exp_valid = have_op && (cyc >= avail);
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        chk("out_result", out_result, e_res);
        chk("out_cmp", out_cmp, e_cmp);
        chk("out_tag", out_tag, e_tag);
      end
      exp_ready = !flush && (!have_op || (exp_valid && out_ready));
      chk("in_ready", in_ready, exp_ready);
      if (out_valid && out_ready) n_consumed++;
      if (flush) have_op = 1'b0;
      else begin
        if (exp_valid && out_ready) have_op = 1'b0;
        if (in_valid && exp_ready) begin
          r       = ref_alu(Operation, SrcA, SrcB);
          have_op = 1'b1;
          e_res   = r[31:0];
          e_cmp   = r[32];
          e_tag   = in_tag;
          avail   = cyc + latency(Operation, SrcB);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1; Operation = op; SrcA = a; SrcB = b; in_tag = tag;
    do begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=no_accept required=accept op=%b", op);
    end
    in_valid = 1'b0;
  endtask

  logic [3:0]  t_op [14] = '{4'b0000, 4'b1101, 4'b1000, 4'b1001, 4'b0100, 4'b0101, 4'b0111,
                             4'b1110, 4'b0011, 4'b1100, 4'b0100, 4'b0010, 4'b1011, 4'b1111};
  logic [31:0] t_a  [14] = '{32'hF0F0_1234, 32'hF000_0000, 32'h55, 32'h55, 32'h1, 32'h8000_0000,
                             32'h7000_0000, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 32'h1234_5678,
                             32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFD};
  logic [31:0] t_b  [14] = '{32'h0FF0_FF00, 32'h0000_000F, 32'h55, 32'h55, 32'd0, 32'd3, 32'd2,
                             32'h9, 32'h1, 32'h1, 32'd33, 32'h1, 32'hFFFF_FFFD, 32'hFFFF_FFFD};

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    Operation = '0; SrcA = '0; SrcB = '0; in_tag = '0;

    // Pin the model with hand-computed values.
    chk("pin_add_wrap", ref_alu(4'b0010, 32'hFFFF_FFFF, 32'd1), 33'h0_0000_0000);
    chk("pin_sra", ref_alu(4'b0111, 32'h8000_0000, 32'd4), 33'h0_F800_0000);
    chk("pin_lt", ref_alu(4'b1011, 32'hFFFF_FFFF, 32'd1), 33'h1_0000_0001);
    chk("pin_ge", ref_alu(4'b1111, 32'hFFFF_FFFF, 32'd1), 33'h0_0000_0000);
    chk("pin_sll31", ref_alu(4'b0100, 32'd1, 32'd31), 33'h0_8000_0000);
    chk("pin_link", ref_alu(4'b1110, 32'hFFFF_FFFE, 32'd0), 33'h0_0000_0002);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_result", out_result, 32'h0);
    chk("reset_out_cmp", out_cmp, 1'b0);
    chk("reset_out_tag", out_tag, 5'd0);
    chk("reset_in_ready", in_ready, 1'b1);
    step();

    send(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd3);
    @(negedge clk);
    chk("add_wrap_valid", out_valid, 1'b1);
    chk("add_wrap_result", out_result, 32'h0);
    chk("add_wrap_tag", out_tag, 5'd3);
    step();

    send(4'b0111, 32'h8000_0000, 32'd4, 5'd4);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("sra_busy_valid", out_valid, 1'b0);
      chk("sra_busy_in_ready", in_ready, 1'b0);
      step();
    end
    @(negedge clk);
    chk("sra_valid", out_valid, 1'b1);
    chk("sra_result", out_result, 32'hF800_0000);
    step();

    send(4'b1011, 32'hFFFF_FFFF, 32'd1, 5'd5);
    @(negedge clk);
    chk("lt_cmp", out_cmp, 1'b1);
    chk("lt_result", out_result, 32'd1);
    step();
    send(4'b1111, 32'hFFFF_FFFF, 32'd1, 5'd6);
    @(negedge clk);
    chk("ge_cmp", out_cmp, 1'b0);
    chk("ge_result", out_result, 32'd0);
    step();

    // Back-to-back table; the model checks each result and its timing.
    for (int i = 0; i < 14; i++) send(t_op[i], t_a[i], t_b[i], 5'(i + 12));
    repeat (8) step();

    // Downstream stall with the next operation already offered.
    out_ready = 1'b0;
    send(4'b0001, 32'h1234_5678, 32'hFFFF_0000, 5'd7);
    in_valid = 1'b1; Operation = 4'b0010; SrcA = 32'd5; SrcB = 32'd6; in_tag = 5'd8;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_result", out_result, 32'hEDCB_5678);
      chk("stall_tag", out_tag, 5'd7);
      chk("stall_in_ready", in_ready, 1'b0);
      step();
    end
    begin
      int c0;
      c0 = n_consumed;
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_in_ready", in_ready, 1'b1);
      step();
      chk("stall_consumed_once", n_consumed - c0, 1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("after_stall_result", out_result, 32'd11);
    chk("after_stall_tag", out_tag, 5'd8);
    step();

    // Flush during a long shift, with another op offered in the flush cycle.
    send(4'b0100, 32'd1, 32'd31, 5'd9);
    repeat (3) step();
    flush = 1'b1; in_valid = 1'b1; Operation = 4'b0000; SrcA = 32'hFF; SrcB = 32'hFF; in_tag = 5'd1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 1'b0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_idle_in_ready", in_ready, 1'b1);
    repeat (35) step();
    send(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd10);
    @(negedge clk);
    chk("post_flush_valid", out_valid, 1'b1);
    chk("post_flush_result", out_result, 32'h0FF0_0FF0);
    chk("post_flush_tag", out_tag, 5'd10);
    step();

    // Reset in the middle of a shift.
    send(4'b0101, 32'hFFFF_FFFF, 32'd20, 5'd11);
    repeat (2) step();
    reset = 1'b1;
    @(negedge clk);
    chk("midshift_rst_in_ready", in_ready, 1'b0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("midshift_rst_valid", out_valid, 1'b0);
    chk("midshift_rst_result", out_result, 32'h0);
    chk("midshift_rst_cmp", out_cmp, 1'b0);
    chk("midshift_rst_tag", out_tag, 5'd0);
    chk("midshift_rst_in_ready", in_ready, 1'b1);
    step();

    send(4'b1001, 32'd1, 32'd2, 5'd2);
    @(negedge clk);
    chk("final_ne_cmp", out_cmp, 1'b1);
    step();
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
